multicycle_control_unit: RTL and testbench

Multi-cycle RV32I control unit: a state machine that sequences each instruction through fetch, decode, execute, memory and writeback, driving the datapath control lines one phase at a time. It replaces the single-cycle combinational decoder between the instruction fetch port, register file, ALU and data memory. It adds variable-latency memory handshakes, a bus timeout, an illegal-instruction trap, and a halt on ECALL/EBREAK.

---
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM
// Sequences fetch/decode/execute/mem/writeback and drives datapath strobes per phase.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_OP_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instruction,
  input  logic                instr_valid,
  input  logic                mem_ready,
  output logic                ifetch_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                halted,
  output logic                illegal_instr
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // Last MEM wait cycle: the counter holds MEM_TIMEOUT-1 during the MEM_TIMEOUT-th cycle.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [31:0] ir;
  logic [7:0]  to_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr;
  logic       is_lui, is_auipc, is_fence, is_system, is_legal;
  logic [3:0] ex_op;

  always_comb begin
    opcode    = ir[6:0];
    funct3    = ir[14:12];
    funct7    = ir[31:25];
    is_r      = (opcode == OP_R);
    is_i      = (opcode == OP_I);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    is_jal    = (opcode == OP_JAL);
    is_jalr   = (opcode == OP_JALR);
    is_lui    = (opcode == OP_LUI);
    is_auipc  = (opcode == OP_AUIPC);
    is_fence  = (opcode == OP_FENCE);
    is_system = (opcode == OP_SYSTEM);
    is_legal  = (is_r && (funct7 == 7'h00 || funct7 == 7'h20)) || is_i || is_load ||
                is_store || is_branch || is_jal || is_jalr || is_lui || is_auipc ||
                is_fence || is_system;
  end

  // ALU operation for EXECUTE; address and link computations all use ADD.
  always_comb begin
    ex_op = 4'd0;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  ex_op = (is_r && ir[30]) ? 4'd1 : 4'd0;
        3'b001:  ex_op = 4'd2;
        3'b010:  ex_op = 4'd3;
        3'b011:  ex_op = 4'd4;
        3'b100:  ex_op = 4'd5;
        3'b101:  ex_op = ir[30] ? 4'd7 : 4'd6;
        3'b110:  ex_op = 4'd8;
        default: ex_op = 4'd9;
      endcase
    end else if (is_branch) begin
      ex_op = 4'd1;
    end else if (is_lui) begin
      ex_op = 4'd10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ir     <= 32'd0;
      to_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (instr_valid) begin
            ir    <= instruction;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!is_legal)
            state <= S_TRAP;
          else if (is_system)
            state <= (ir == ECALL || ir == EBREAK) ? S_HALT : S_TRAP;
          else
            state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (is_branch || is_fence) begin
            state <= S_FETCH;
          end else if (is_load || is_store) begin
            to_cnt <= 8'd0;
            state  <= S_MEM;
          end else begin
            state <= S_WRITEBACK;
          end
        end
        S_MEM: begin
          // A completion in the final allowed cycle takes priority over the timeout.
          if (mem_ready)
            state <= is_load ? S_WRITEBACK : S_FETCH;
          else if (to_cnt == TO_LAST)
            state <= S_TRAP;
          else
            to_cnt <= to_cnt + 8'd1;
        end
        S_WRITEBACK: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        S_TRAP:      state <= S_TRAP;
        default:     state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ifetch_req    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src       = 1'b0;
    alu_op        = '0;
    reg_write     = 1'b0;
    halted        = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        ifetch_req = 1'b1;
        ir_write   = instr_valid;
      end
      S_EXECUTE: begin
        alu_op[3:0] = ex_op;
        alu_src     = is_i || is_load || is_store || is_lui || is_auipc || is_jal || is_jalr;
        branch      = is_branch || is_jal || is_jalr;
        pc_write    = is_branch || is_fence;
      end
      S_MEM: begin
        mem_read  = is_load;
        mem_write = is_store;
        pc_write  = is_store && mem_ready;
      end
      S_WRITEBACK: begin
        reg_write  = (ir[11:7] != 5'd0);
        mem_to_reg = is_load;
        branch     = is_jal || is_jalr;
        pc_write   = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  illegal_instr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - table-driven bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        mem_ready;
  logic        ifetch_req, ir_write, pc_write, branch, mem_read, mem_write;
  logic        mem_to_reg, alu_src, reg_write, halted, illegal_instr;
  logic [3:0]  alu_op;

  multicycle_control_unit #(.MEM_TIMEOUT(16), .ALU_OP_W(4)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .ifetch_req(ifetch_req), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
    .halted(halted), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // Output vector: {alu_op, ifetch_req, ir_write, pc_write, branch, mem_read,
  // mem_write, mem_to_reg, alu_src, reg_write, halted, illegal_instr}
  logic [14:0] ov;
  assign ov = {alu_op, ifetch_req, ir_write, pc_write, branch, mem_read, mem_write,
               mem_to_reg, alu_src, reg_write, halted, illegal_instr};

  localparam logic [14:0] ILL = 15'h0001, HLT = 15'h0002, RW = 15'h0004, ASRC = 15'h0008;
  localparam logic [14:0] M2R = 15'h0010, MW = 15'h0020, MR = 15'h0040, BR = 15'h0080;
  localparam logic [14:0] PCW = 15'h0100, IRW = 15'h0200, IFR = 15'h0400;

  function automatic logic [14:0] aop(input int n);
    return 15'(n << 11);
  endfunction

  typedef struct {
    logic [31:0] instr;
    int          delay;   // mem_ready low for this many MEM cycles; -1 = never
    int          cycles;
    logic [14:0] ex;
    logic [14:0] last;
    int          mem_cyc;
    int          kind;    // 0 retire, 1 halt, 2 trap
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_idle_outputs", 32'(ov), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'(ov), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_entry(input int idx, input vec_t e);
    int cyc, w, mc, pcw, kind;
    logic [14:0] v, first, exv, last;
    string tag;
    cyc = 0; w = 0; mc = 0; pcw = 0; kind = 0;
    first = '0; exv = '0; last = '0;
    tag = $sformatf("v%0d_%08h", idx, e.instr);
    instruction = e.instr;
    instr_valid = 1'b1;
    mem_ready   = 1'b0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      v = ov;
      if (v[6] || v[5]) begin
        if (e.delay >= 0 && w >= e.delay) mem_ready = 1'b1;
        w++;
        mc++;
        #1;
        v = ov;
      end
      cyc++;
      if (cyc == 1) first = v;
      if (cyc == 2) instr_valid = 1'b0;
      if (cyc == 3) exv = v;
      if (v[8]) pcw++;
      last = v;
      if (v[1]) begin kind = 1; break; end
      if (v[0]) begin kind = 2; break; end
      if (v[8]) begin
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        break;
      end
      if (cyc >= 200) begin
        chk({tag, "_timeout"}, 32'(cyc), 32'(e.cycles));
        break;
      end
    end
    chk({tag, "_fetch"}, 32'(first), 32'(IFR | IRW));
    chk({tag, "_cycles"}, 32'(cyc), 32'(e.cycles));
    chk({tag, "_execute"}, 32'(exv), 32'(e.ex));
    chk({tag, "_last"}, 32'(last), 32'(e.last));
    chk({tag, "_mem_cycles"}, 32'(mc), 32'(e.mem_cyc));
    chk({tag, "_end"}, 32'(kind), 32'(e.kind));
    chk({tag, "_pc_writes"}, 32'(pcw), (e.kind == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    tbl[0]  = '{32'h00300293,  0, 4,  ASRC,           RW | PCW,        0, 0}; // ADDI x5
    tbl[1]  = '{32'h00002303,  0, 5,  ASRC,           RW | M2R | PCW,  1, 0}; // LW
    tbl[2]  = '{32'h00202223,  0, 4,  ASRC,           MW | PCW,        1, 0}; // SW
    tbl[3]  = '{32'h00050663,  0, 3,  aop(1)|BR|PCW,  aop(1)|BR|PCW,   0, 0}; // BEQ
    tbl[4]  = '{32'h000000EF,  0, 4,  BR | ASRC,      BR | RW | PCW,   0, 0}; // JAL x1
    tbl[5]  = '{32'hFFFFF037,  0, 4,  aop(10)|ASRC,   PCW,             0, 0}; // LUI x0
    tbl[6]  = '{32'h40B50533,  0, 4,  aop(1),         RW | PCW,        0, 0}; // SUB
    tbl[7]  = '{32'h4012D293,  0, 4,  aop(7)|ASRC,    RW | PCW,        0, 0}; // SRAI
    tbl[8]  = '{32'h0020F1B3,  0, 4,  aop(9),         RW | PCW,        0, 0}; // AND
    tbl[9]  = '{32'h0000000F,  0, 3,  PCW,            PCW,             0, 0}; // FENCE
    tbl[10] = '{32'h00513093,  0, 4,  aop(4)|ASRC,    RW | PCW,        0, 0}; // SLTIU
    tbl[11] = '{32'h000100E7,  0, 4,  BR | ASRC,      BR | RW | PCW,   0, 0}; // JALR x1
    tbl[12] = '{32'h00001397,  0, 4,  ASRC,           RW | PCW,        0, 0}; // AUIPC x7
    tbl[13] = '{32'h00002303,  3, 8,  ASRC,           RW | M2R | PCW,  4, 0}; // LW, slow
    tbl[14] = '{32'h00202223, 15, 19, ASRC,           MW | PCW,       16, 0}; // SW, ready on 16th
    tbl[15] = '{32'h00202223, -1, 20, ASRC,           ILL,            16, 2}; // SW timeout
    tbl[16] = '{32'hFFFFFFFF,  0, 3,  ILL,            ILL,             0, 2}; // bad opcode
    tbl[17] = '{32'h02000033,  0, 3,  ILL,            ILL,             0, 2}; // R funct7=0x01
    tbl[18] = '{32'h00200073,  0, 3,  ILL,            ILL,             0, 2}; // other SYSTEM

    rst = 1'b1; instruction = 32'd0; instr_valid = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 19; i++) begin
      run_entry(i, tbl[i]);
      if (tbl[i].kind != 0) do_reset();
    end

    // EBREAK: halt is absorbing and never writes PC.
    run_entry(100, '{32'h00100073, 0, 3, HLT, HLT, 0, 1});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("halt_hold_%0d", c), 32'(ov), 32'(HLT));
    end
    do_reset();

    // Trap is absorbing too, even with fetch inputs active.
    run_entry(101, '{32'hFFFFFFFF, 0, 3, ILL, ILL, 0, 2});
    instr_valid = 1'b1;
    mem_ready   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("trap_hold_%0d", c), 32'(ov), 32'(ILL));
    end
    do_reset();

    // Reset during the second MEM wait cycle of a load.
    instruction = 32'h00002303;
    instr_valid = 1'b1;
    mem_ready   = 1'b0;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midmem_wait1", 32'(ov), 32'(MR));
    @(posedge clk); #1;
    @(negedge clk);
    chk("midmem_wait2", 32'(ov), 32'(MR));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midmem_reset_idle", 32'(ov), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midmem_idle", 32'(ov), 32'd0);
    @(posedge clk); #1;
    run_entry(102, tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
